pair_sequencer: RTL and testbench

PAIR_SEQUENCER -- requirements
Module: pair_sequencer

---
 rtl/pair_sequencer_if.sv | 28 ++
 rtl/pair_sequencer.sv | 147 ++++++++++++++
 tb/tb_pair_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pair_sequencer_if.sv
// rtl/pair_sequencer_if.sv - control, read-address and write-back bundle of the all-pairs sequencer
interface pair_sequencer_if #(
  parameter int W = 9
);
  logic         start;
  logic         abort;
  logic [W-1:0] num_bodies;
  logic         busy;
  logic [W-1:0] rd_i;
  logic [W-1:0] rd_j;
  logic         rd_valid;
  logic [W-1:0] wb_i;
  logic [W-1:0] wb_j;
  logic         wb_valid;
  logic         wb_self;
  logic         wb_row_last;
  logic         done;

  modport master (
    output start, abort, num_bodies,
    input  busy, rd_i, rd_j, rd_valid, wb_i, wb_j, wb_valid, wb_self, wb_row_last, done
  );

  modport slave (
    input  start, abort, num_bodies,
    output busy, rd_i, rd_j, rd_valid, wb_i, wb_j, wb_valid, wb_self, wb_row_last, done
  );
endinterface

// File: rtl/pair_sequencer.sv
// rtl/pair_sequencer.sv - row-major all-pairs index generator with a fixed-latency tag line
// aligning write-back indices with the accel pipeline output.
module pair_sequencer #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int PIPE_LAT        = 123
) (
  input  logic           clk,
  input  logic           rst_n,
  pair_sequencer_if.slave bus
);
  localparam int W = BODY_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic         self_pair;
    logic         row_last;
  } stage_t;

  state_t       state_q, state_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  // Marks the extra FIN cycle for N < 2, so done still lands two cycles after start.
  logic         degen_q, degen_d;
  stage_t       pipe_q [PIPE_LAT];
  stage_t       pipe_d [PIPE_LAT];

  logic [W-1:0] n_last;
  logic         issue;
  logic         row_end;
  logic         sweep_end;
  logic         wb_last;
  logic         flush;

  always_comb begin
    n_last    = n_q - W'(1);
    issue     = (state_q == S_ISSUE);
    row_end   = (j_q == n_last);
    sweep_end = row_end && (i_q == n_last);
    wb_last   = pipe_q[PIPE_LAT-1].valid && (pipe_q[PIPE_LAT-1].i == n_last)
                && (pipe_q[PIPE_LAT-1].j == n_last);
    flush     = bus.abort && (state_q != S_IDLE);

    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    degen_d = degen_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          n_d = bus.num_bodies;
          if (bus.num_bodies > W'(1)) begin
            state_d = S_ISSUE;
            i_d     = '0;
            j_d     = '0;
          end else begin
            state_d = S_FIN;
            degen_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (sweep_end) begin
          state_d = S_DRAIN;
        end else if (row_end) begin
          j_d = '0;
          i_d = i_q + W'(1);
        end else begin
          j_d = j_q + W'(1);
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (wb_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          degen_d = 1'b0;
        end else if (degen_q) begin
          degen_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Tag line shifts unconditionally; the accel pipeline never stalls.
    pipe_d[0].valid     = issue;
    pipe_d[0].i         = i_q;
    pipe_d[0].j         = j_q;
    pipe_d[0].self_pair = issue && (i_q == j_q);
    pipe_d[0].row_last  = issue && row_end;
    for (int k = 1; k < PIPE_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    if (flush) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        pipe_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      degen_q <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      degen_q <= degen_d;
      pipe_q  <= pipe_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FIN) && !degen_q;
  assign bus.rd_valid    = issue;
  assign bus.rd_i        = i_q;
  assign bus.rd_j        = j_q;
  assign bus.wb_valid    = pipe_q[PIPE_LAT-1].valid;
  assign bus.wb_i        = pipe_q[PIPE_LAT-1].i;
  assign bus.wb_j        = pipe_q[PIPE_LAT-1].j;
  assign bus.wb_self     = pipe_q[PIPE_LAT-1].self_pair;
  assign bus.wb_row_last = pipe_q[PIPE_LAT-1].row_last;
endmodule

// File: tb/tb_pair_sequencer.sv
// tb/tb_pair_sequencer.sv - table-driven bench for pair_sequencer with a 4-cycle pipeline
module tb_pair_sequencer;
  localparam int W   = 9;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pair_sequencer_if #(.W(W)) bus ();

  pair_sequencer #(.BODIES(512), .BODY_ADDR_WIDTH(W), .PIPE_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         start;
    logic         abort;
    logic [W-1:0] nb;
    logic         busy;
    logic         rd_valid;
    logic [W-1:0] rd_i;
    logic [W-1:0] rd_j;
    logic         wb_valid;
    logic [W-1:0] wb_i;
    logic [W-1:0] wb_j;
    logic         wb_self;
    logic         wb_row_last;
    logic         done;
  } vec_t;

  vec_t tbl [40];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hi = 0;
  int   hj = 0;

  // Expected outputs at cycle c for a sweep of n bodies started at cycle s,
  // with (hi, hj) being the read address held from before the sweep.
  function automatic vec_t exp_at(int c, int n, int s, int hold_i, int hold_j);
    vec_t v;
    int   p;
    int   last_issue;
    int   done_c;
    v = '{default: '0};
    v.rd_i = W'(hold_i);
    v.rd_j = W'(hold_j);
    if (n < 2) begin
      done_c = s + 2;
    end else begin
      last_issue = s + n * n;
      done_c     = last_issue + LAT + 1;
      if (c > s && c <= last_issue) begin
        p          = c - s - 1;
        v.rd_valid = 1'b1;
        v.rd_i     = W'(p / n);
        v.rd_j     = W'(p % n);
      end else if (c > last_issue) begin
        v.rd_i = W'(n - 1);
        v.rd_j = W'(n - 1);
      end
      if (c > s + LAT && c <= last_issue + LAT) begin
        p             = c - s - 1 - LAT;
        v.wb_valid    = 1'b1;
        v.wb_i        = W'(p / n);
        v.wb_j        = W'(p % n);
        v.wb_self     = ((p / n) == (p % n));
        v.wb_row_last = ((p % n) == n - 1);
      end
    end
    v.busy = (c > s) && (c <= done_c);
    v.done = (c == done_c);
    return v;
  endfunction

  function automatic logic [41:0] pack_vec(vec_t v);
    return {v.busy, v.rd_valid, v.rd_i, v.rd_j, v.wb_valid, v.wb_i, v.wb_j,
            v.wb_self, v.wb_row_last, v.done};
  endfunction

  function automatic logic [41:0] pack_dut();
    return {bus.busy, bus.rd_valid, bus.rd_i, bus.rd_j, bus.wb_valid, bus.wb_i, bus.wb_j,
            bus.wb_self, bus.wb_row_last, bus.done};
  endfunction

  task automatic fill_sweep(int n, int s, int len, int nb);
    for (int c = 0; c < len; c++) begin
      tbl[c]       = exp_at(c, n, s, hi, hj);
      tbl[c].nb    = W'(nb);
      tbl[c].start = (c == s);
    end
  endtask

  task automatic run_table(string name, int len);
    logic [41:0] act;
    logic [41:0] exp;
    logic [41:0] msk;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bus.start      = tbl[k].start;
      bus.abort      = tbl[k].abort;
      bus.num_bodies = tbl[k].nb;
      msk = '1;
      if (!tbl[k].wb_valid) msk[20:3] = '0;
      act = pack_dut() & msk;
      exp = pack_vec(tbl[k]) & msk;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h, want %h", name, k, act, exp);
      end
    end
  endtask

  task automatic idle(int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_bodies = '0;

    #12;
    n_cmp++;
    if (pack_dut() !== 42'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h, want 0", pack_dut());
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    fill_sweep(3, 0, 17, 3);
    run_table("n3_sweep", 17);
    hi = 2; hj = 2;
    idle(2);

    fill_sweep(3, 0, 17, 3);
    tbl[3].start = 1'b1;  tbl[3].nb  = W'(5);
    tbl[12].start = 1'b1; tbl[12].nb = W'(5);
    run_table("n3_restart_ignored", 17);
    idle(2);

    fill_sweep(1, 0, 5, 1);
    run_table("n1_degenerate", 5);
    idle(2);
    fill_sweep(0, 0, 5, 0);
    run_table("n0_degenerate", 5);
    idle(2);

    for (int c = 0; c < 4; c++) begin
      tbl[c]    = exp_at(c, 3, 100, hi, hj);
      tbl[c].nb = W'(3);
    end
    tbl[0].start = 1'b1;
    tbl[0].abort = 1'b1;
    run_table("abort_beats_start", 4);
    idle(2);

    fill_sweep(4, 0, 24, 4);
    run_table("n4_sweep", 24);
    hi = 3; hj = 3;
    idle(2);

    for (int c = 0; c < 7; c++) begin
      tbl[c]       = exp_at(c, 3, 0, hi, hj);
      tbl[c].nb    = W'(3);
      tbl[c].start = (c == 0);
    end
    tbl[6].abort = 1'b1;
    tbl[7]    = exp_at(7, 3, 100, 1, 2);
    tbl[7].nb = W'(3);
    for (int c = 8; c < 25; c++) begin
      tbl[c]       = exp_at(c, 3, 8, 1, 2);
      tbl[c].nb    = W'(3);
      tbl[c].start = (c == 8);
    end
    run_table("abort_restart", 25);
    hi = 2; hj = 2;
    idle(2);

    fill_sweep(3, 0, 7, 3);
    run_table("pre_reset", 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pack_dut() !== 42'd0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %h, want 0", pack_dut());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.rd_valid, bus.wb_valid, bus.done} !== 4'b0000) begin
        n_bad++;
        $display("FAIL post_reset_quiet cycle %0d: got %b, want 0000", k,
                 {bus.busy, bus.rd_valid, bus.wb_valid, bus.done});
      end
    end
    hi = 0; hj = 0;

    fill_sweep(2, 0, 13, 2);
    run_table("n2_after_reset", 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
